// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and defaults for the single-port memory arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W_DEF / DATA_W_DEF / STARVE_MAX_DEF - default widths and starvation limit
//   port_t  - identifies the fetch (PORT_IF) or data (PORT_DM) requester
//   state_t - read-outstanding tracking: IDLE, RD_IF, RD_DM
//   next_state() - which read (if any) the current grant leaves outstanding
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_DM = 2'd2
    } state_t;

    // A fetch grant is always a read; a data grant is a read only when dm_we=0.
    // Grants are mutually exclusive, so the fetch test can come first.
    function automatic state_t next_state(input logic if_gnt,
                                          input logic dm_gnt,
                                          input logic dm_we);
        state_t ns;
        ns = IDLE;
        if (if_gnt) begin
            ns = RD_IF;
        end else if (dm_gnt && !dm_we) begin
            ns = RD_DM;
        end
        return ns;
    endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Purpose : combinational grant picker for the fetch/data memory arbiter.
// Latency : zero cycles, pure combinational decode of requests and state.
// Backpressure: a losing requester simply sees no grant and must hold its request.
//
// Ports:
//   block    in  forces both grants low (used while the arbiter is in reset)
//   if_req   in  fetch request
//   dm_req   in  data request
//   last_gnt in  port granted most recently (PORT_IF / PORT_DM encoding)
//   starve   in  fetch starvation counter has reached its limit
//   if_gnt   out fetch granted this cycle
//   dm_gnt   out data granted this cycle
//
// Build option: MEM_ARB_RR_EN selects round-robin contention resolution;
// otherwise data wins contention unless the fetch side is starving.
import mem_arb_pkg::*;

module mem_arb_sel (
    input  logic block,
    input  logic if_req,
    input  logic dm_req,
    input  logic last_gnt,
    input  logic starve,
    output logic if_gnt,
    output logic dm_gnt
);

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!block) begin
            if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
                // Alternate: whoever was not served last wins.
                if (last_gnt == PORT_DM) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
`else
                // Data has fixed priority; a starving fetch overrides it once.
                if (starve) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
`endif
            end else begin
                // A lone requester is always served immediately.
                if_gnt = if_req;
                dm_gnt = dm_req;
            end
        end
    end

    // Input not consulted in this build; sink it so it is not left dangling.
`ifdef MEM_ARB_RR_EN
    logic unused_starve;
    assign unused_starve = starve;
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates a fetch port and a data port onto one synchronous memory.
// Latency : grant and memory command in the request cycle; read data 1 cycle later.
// Backpressure: level-sensitive requests, no queue; a denied port holds its request.
//
// Ports:
//   clk, rst                                  clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_stall   fetch port (read only)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt/dm_rvalid/dm_rdata   data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata  memory port (read data 1 cycle after mem_en)
//
// Build option: define MEM_ARB_RR_EN for round-robin contention handling; by
// default data has priority and the fetch side gets a forced grant after
// STARVE_MAX consecutive denials.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t             state;
    port_t              last_gnt;
    logic [CNT_W-1:0]   starve_cnt;
    logic               starve;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  dm_rdata_q;

    assign starve = (starve_cnt == STARVE_LIM);

    // Reset blocks every grant so nothing reaches the memory during reset.
    mem_arb_sel u_sel (
        .block    (rst),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .last_gnt (last_gnt),
        .starve   (starve),
        .if_gnt   (if_gnt),
        .dm_gnt   (dm_gnt)
    );

    assign if_stall = if_req & ~if_gnt;

    // Memory command follows the winner; idle bus is driven to zero.
    assign mem_en    = if_gnt | dm_gnt;
    assign mem_we    = dm_gnt & dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = mem_we ? dm_wdata : '0;

    // The outstanding-read state says whose data is on mem_rdata this cycle.
    // Gating with rst drops a read that was granted just before reset, so no
    // response is ever delivered across a reset.
    assign if_rvalid = (state == RD_IF) & ~rst;
    assign dm_rvalid = (state == RD_DM) & ~rst;

    // Live data while valid, otherwise the last value delivered on that port.
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= PORT_IF;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_rvalid) begin
                dm_rdata_q <= mem_rdata;
            end

            // A new grant overwrites the state every cycle, so back-to-back
            // reads pipeline without a bubble.
            state <= next_state(if_gnt, dm_gnt, dm_we);

            if (if_gnt) begin
                last_gnt <= PORT_IF;
            end else if (dm_gnt) begin
                last_gnt <= PORT_DM;
            end

`ifdef MEM_ARB_RR_EN
            starve_cnt <= '0;
`else
            // Counts consecutive denials of a waiting fetch; any fetch grant
            // or a dropped request restarts the count.
            if (if_req && !if_gnt) begin
                if (!starve) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
`endif
        end
    end

endmodule
